// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of a single-outstanding memory port.
// Latency: grant T, mem_req T+1, completion accepted from T+2, response T+3, next grant T+4 earliest.
// Backpressure: requesters hold req until gnt; memory has no stall, a missing completion times out.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [DW/8-1:0] ls_be_i,
    input  logic [AW-1:0]   ls_addr_i,
    input  logic [DW-1:0]   ls_wdata_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q;
    logic [TW-1:0]   wait_q;
    logic            owner_if_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            pick_if, pick_ls;
    logic            wait_expired;

    assign wait_expired = (wait_q == TW'(TIMEOUT - 1));

    // Load/store wins unless fetch has already been passed over STARVE_MAX times.
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (state_q == IDLE && rst_n_i) begin
            if (if_req_i && (!ls_req_i || starve_q == SW'(STARVE_MAX)))
                pick_if = 1'b1;
            else if (ls_req_i)
                pick_ls = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_if || pick_ls) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mem_rvalid_i || wait_expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            owner_if_q  <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q <= state_d;

            if (pick_if)
                starve_q <= '0;
            else if (pick_ls && if_req_i && starve_q != SW'(STARVE_MAX))
                starve_q <= starve_q + 1'b1;

            // Payload stays on the mem_* pins until the next grant overwrites it.
            if (pick_if || pick_ls) begin
                owner_if_q  <= pick_if;
                mem_we_o    <= pick_ls & ls_we_i;
                mem_be_o    <= pick_ls ? ls_be_i : '1;
                mem_addr_o  <= pick_ls ? ls_addr_i : if_addr_i;
                mem_wdata_o <= pick_ls ? ls_wdata_i : '0;
            end

            if (state_q == ISSUE)
                wait_q <= '0;
            else if (state_q == WAIT)
                wait_q <= wait_q + 1'b1;

            // Completion wins over timeout when both land in the last WAIT cycle.
            if (state_q == WAIT) begin
                if (mem_rvalid_i) begin
                    rdata_q <= mem_we_o ? '0 : mem_rdata_i;
                    err_q   <= 1'b0;
                end else if (wait_expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign if_gnt_o    = pick_if;
    assign ls_gnt_o    = pick_ls;
    assign mem_req_o   = rst_n_i && (state_q == ISSUE);
    assign if_rvalid_o = rst_n_i && (state_q == RESP) && owner_if_q;
    assign ls_rvalid_o = rst_n_i && (state_q == RESP) && !owner_if_q;
    assign rdata_o     = (rst_n_i && state_q == RESP) ? rdata_q : '0;
    assign err_o       = rst_n_i && (state_q == RESP) && err_q;
endmodule
